// File: rtl/bet_scorer.sv
// rtl/bet_scorer.sv - lottery bet scorer: latches a draw, scores serial 3-number tickets, sequences V/finish for the display stage
module bet_scorer #(
  parameter int PRIZE1      = 3,
  parameter int PRIZE2      = 27,
  parameter int PRIZE3      = 250,
  parameter int SUM_MAX     = 799,
  parameter int MAX_TICKETS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_draw,
  input  logic [17:0] draw_in,
  input  logic [5:0]  N_in,
  input  logic        N_valid,
  input  logic        end_bets,
  output logic [9:0]  sum,
  output logic        V,
  output logic        finish,
  output logic [3:0]  tickets,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_BET   = 3'd2;
  localparam logic [2:0] S_CLOSE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam logic [9:0]  P1   = 10'(PRIZE1);
  localparam logic [9:0]  P2   = 10'(PRIZE2);
  localparam logic [9:0]  P3   = 10'(PRIZE3);
  localparam logic [10:0] SMAX = 11'(SUM_MAX);
  localparam logic [3:0]  TMAX = 4'(MAX_TICKETS);

  logic [2:0] state_q, state_d;
  logic [5:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] mcnt_q, mcnt_d;
  logic [9:0] sum_q, sum_d;
  logic [3:0] tickets_q, tickets_d;
  logic       v_q, v_d;
  logic       fin_q, fin_d;
  logic       err_q, err_d;

  logic [5:0]  nd0, nd1, nd2;
  logic        draw_ok, n_ok, hit;
  logic [1:0]  total_hits;
  logic [9:0]  prize;
  logic [10:0] sum_wide;
  logic [9:0]  sum_sat;
  logic [3:0]  tickets_inc;

  function automatic logic num_ok(input logic [5:0] n);
    return (n >= 6'd1) && (n <= 6'd49);
  endfunction

  assign nd0 = draw_in[17:12];
  assign nd1 = draw_in[11:6];
  assign nd2 = draw_in[5:0];

  // Draw must be three legal, pairwise-distinct numbers, so a bet can hit at most one of them
  assign draw_ok = num_ok(nd0) && num_ok(nd1) && num_ok(nd2) &&
                   (nd0 != nd1) && (nd0 != nd2) && (nd1 != nd2);
  assign n_ok    = num_ok(N_in);
  assign hit     = (N_in == d0_q) || (N_in == d1_q) || (N_in == d2_q);

  // mcnt holds at most 2 before the third number, so the total fits in 2 bits
  assign total_hits  = mcnt_q + {1'b0, hit};
  assign sum_wide    = {1'b0, sum_q} + {1'b0, prize};
  assign sum_sat     = (sum_wide > SMAX) ? SMAX[9:0] : sum_wide[9:0];
  assign tickets_inc = tickets_q + 4'd1;

  // Prize table indexed by the completed ticket's match count
  always_comb begin
    prize = 10'd0;
    case (total_hits)
      2'd1:    prize = P1;
      2'd2:    prize = P2;
      2'd3:    prize = P3;
      default: prize = 10'd0;
    endcase
  end

  // Next-state logic for the game sequencer and the scoring datapath
  always_comb begin
    state_d   = state_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    idx_d     = idx_q;
    mcnt_d    = mcnt_q;
    sum_d     = sum_q;
    tickets_d = tickets_q;
    v_d       = v_q;
    fin_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_draw) begin
          if (draw_ok) begin
            d0_d    = nd0;
            d1_d    = nd1;
            d2_d    = nd2;
            state_d = S_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ARMED, S_HOLD: begin
        // A new draw wins over a coincident bet number
        if (load_draw) begin
          if (draw_ok) begin
            d0_d = nd0;
            d1_d = nd1;
            d2_d = nd2;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (N_valid && !n_ok) err_d = 1'b1;
          if ((state_q == S_ARMED) && end_bets) begin
            sum_d     = 10'd0;
            tickets_d = 4'd0;
            state_d   = S_CLOSE;
          end else if (N_valid && n_ok) begin
            sum_d     = 10'd0;
            tickets_d = 4'd0;
            v_d       = 1'b1;
            idx_d     = 2'd1;
            mcnt_d    = {1'b0, hit};
            state_d   = S_BET;
          end
        end
      end
      S_BET: begin
        if (N_valid) begin
          if (n_ok) begin
            if (idx_q == 2'd2) begin
              sum_d     = sum_sat;
              tickets_d = tickets_inc;
              idx_d     = 2'd0;
              mcnt_d    = 2'd0;
            end else begin
              idx_d  = idx_q + 2'd1;
              mcnt_d = total_hits;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        // The number above is scored first; closing then discards any partial ticket
        if (end_bets || (N_valid && n_ok && (idx_q == 2'd2) && (tickets_inc == TMAX))) begin
          v_d     = 1'b0;
          idx_d   = 2'd0;
          mcnt_d  = 2'd0;
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        v_d     = 1'b0;
        idx_d   = 2'd0;
        mcnt_d  = 2'd0;
        fin_d   = 1'b1;
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_HOLD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      d0_q      <= 6'd0;
      d1_q      <= 6'd0;
      d2_q      <= 6'd0;
      idx_q     <= 2'd0;
      mcnt_q    <= 2'd0;
      sum_q     <= 10'd0;
      tickets_q <= 4'd0;
      v_q       <= 1'b0;
      fin_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      idx_q     <= idx_d;
      mcnt_q    <= mcnt_d;
      sum_q     <= sum_d;
      tickets_q <= tickets_d;
      v_q       <= v_d;
      fin_q     <= fin_d;
      err_q     <= err_d;
    end
  end

  assign sum     = sum_q;
  assign V       = v_q;
  assign finish  = fin_q;
  assign tickets = tickets_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bet_scorer.sv
// tb/tb_bet_scorer.sv - self-checking bench for bet_scorer: directed scenarios plus randomized traffic against a ticket-level model
module tb_bet_scorer;
  localparam int P1 = 3, P2 = 27, P3 = 250, SMAX = 799, MAXT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_draw = 1'b0;
  logic [17:0] draw_in = 18'd0;
  logic [5:0]  N_in = 6'd0;
  logic        N_valid = 1'b0;
  logic        end_bets = 1'b0;
  logic [9:0]  sum;
  logic        V;
  logic        finish;
  logic [3:0]  tickets;
  logic        err;

  bet_scorer dut (
    .clk(clk), .reset(reset), .load_draw(load_draw), .draw_in(draw_in),
    .N_in(N_in), .N_valid(N_valid), .end_bets(end_bets),
    .sum(sum), .V(V), .finish(finish), .tickets(tickets), .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: phase 0 no draw, 1 draw loaded, 2 betting, 3 closing, 4 finishing, 5 holding result
  int ph;
  int dr[3];
  int tk[$];
  int s, t;
  bit v, f, er;

  function automatic bit legal(int n);
    return (n >= 1) && (n <= 49);
  endfunction

  function automatic bit draw_legal(logic [17:0] d);
    int a, b, c;
    a = int'(d[17:12]);
    b = int'(d[11:6]);
    c = int'(d[5:0]);
    return legal(a) && legal(b) && legal(c) && (a != b) && (a != c) && (b != c);
  endfunction

  function automatic int prize_of(int m);
    if (m == 1) return P1;
    if (m == 2) return P2;
    if (m == 3) return P3;
    return 0;
  endfunction

  function automatic logic [17:0] pack(int a, int b, int c);
    return {6'(a), 6'(b), 6'(c)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic model_reset();
    ph = 0;
    dr[0] = 0; dr[1] = 0; dr[2] = 0;
    tk.delete();
    s = 0; t = 0; v = 0; f = 0; er = 0;
  endtask

  task automatic take_draw(logic [17:0] d);
    dr[0] = int'(d[17:12]);
    dr[1] = int'(d[11:6]);
    dr[2] = int'(d[5:0]);
  endtask

  task automatic model_step();
    int n, m;
    if (!reset) begin
      model_reset();
      return;
    end
    n  = int'(N_in);
    er = 0;
    f  = 0;
    case (ph)
      0: if (load_draw) begin
           if (draw_legal(draw_in)) begin take_draw(draw_in); ph = 1; end
           else er = 1;
         end
      1, 5: begin
        if (load_draw) begin
          if (draw_legal(draw_in)) take_draw(draw_in);
          else er = 1;
        end else begin
          if (N_valid && !legal(n)) er = 1;
          if (ph == 1 && end_bets) begin
            s = 0; t = 0; ph = 3;
          end else if (N_valid && legal(n)) begin
            s = 0; t = 0; v = 1;
            tk.delete();
            tk.push_back(n);
            ph = 2;
          end
        end
      end
      2: begin
        if (N_valid) begin
          if (legal(n)) begin
            tk.push_back(n);
            if (tk.size() == 3) begin
              m = 0;
              foreach (tk[i]) if (tk[i] == dr[0] || tk[i] == dr[1] || tk[i] == dr[2]) m++;
              s = s + prize_of(m);
              if (s > SMAX) s = SMAX;
              t++;
              tk.delete();
            end
          end else begin
            er = 1;
          end
        end
        if (end_bets || t == MAXT) begin
          v = 0; ph = 3;
          tk.delete();
        end
      end
      3: begin f = 1; ph = 4; end
      4: ph = 5;
      default: ph = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("sum", 32'(sum), 32'(s));
    chk("V", 32'(V), 32'(v));
    chk("finish", 32'(finish), 32'(f));
    chk("tickets", 32'(tickets), 32'(t));
    chk("err", 32'(err), 32'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(bit ld, logic [17:0] d, bit nv, logic [5:0] n, bit eb);
    load_draw = ld; draw_in = d; N_valid = nv; N_in = n; end_bets = eb;
    tick();
    load_draw = 0; N_valid = 0; end_bets = 0;
  endtask

  task automatic bet(int n);
    drive(0, 18'd0, 1, 6'(n), 0);
  endtask

  task automatic do_reset();
    load_draw = 0; N_valid = 0; end_bets = 0;
    reset = 0;
    #1;
    model_reset();
    check_outputs();
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    int a, b, c, n;
    bit ld, nv, eb;
    int exp_sums[4];
    exp_sums = '{250, 500, 750, 799};
    model_reset();
    tick();
    chk("reset_sum", 32'(sum), 0);
    chk("reset_V", 32'(V), 0);
    reset = 1;
    tick();

    // Two scored tickets, a discarded partial, then the close sequence
    drive(1, pack(7, 19, 42), 0, 0, 0);
    bet(7); bet(19); bet(3);
    chk("t1_sum27", 32'(sum), 27);
    bet(42); bet(19); bet(7);
    chk("t1_sum277", 32'(sum), 277);
    chk("t1_tickets2", 32'(tickets), 2);
    bet(7);
    drive(0, 0, 0, 0, 1);
    chk("t1_V_fall", 32'(V), 0);
    chk("t1_fin_low", 32'(finish), 0);
    tick();
    chk("t1_fin_high", 32'(finish), 1);
    tick();
    chk("t1_fin_fall", 32'(finish), 0);
    chk("t1_hold_sum", 32'(sum), 277);

    // Saturation at the ceiling
    for (int k = 0; k < 4; k++) begin
      bet(7); bet(19); bet(42);
      chk("t2_sat_sum", 32'(sum), 32'(exp_sums[k]));
    end
    drive(0, 0, 0, 0, 1);
    tick(); tick();

    // Illegal numbers are rejected without advancing the ticket
    bet(0);
    chk("t3_err0", 32'(err), 1);
    bet(50);
    chk("t3_err50", 32'(err), 1);
    bet(19);
    chk("t3_err_clear", 32'(err), 0);
    chk("t3_V_start", 32'(V), 1);
    bet(7); bet(42);
    chk("t3_one_ticket", 32'(tickets), 1);
    chk("t3_sum", 32'(sum), 250);
    drive(0, 0, 0, 0, 1);
    tick(); tick();

    // Duplicate draw is rejected and the block stays without a draw
    do_reset();
    drive(1, pack(5, 5, 9), 0, 0, 0);
    chk("t4_err_draw", 32'(err), 1);
    bet(5);
    chk("t4_no_V", 32'(V), 0);
    chk("t4_no_err", 32'(err), 0);

    // Fifteen single-match tickets close the game automatically
    drive(1, pack(7, 19, 42), 0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      bet(7); bet(1); bet(2);
    end
    chk("t5_sum45", 32'(sum), 45);
    chk("t5_tickets15", 32'(tickets), 15);
    chk("t5_V_auto", 32'(V), 0);
    tick();
    chk("t5_fin", 32'(finish), 1);
    tick();

    // Asynchronous reset mid-ticket
    bet(7); bet(19); bet(3);
    chk("t6_sum27", 32'(sum), 27);
    bet(7);
    reset = 0;
    #1;
    model_reset();
    chk("t6_async_sum", 32'(sum), 0);
    chk("t6_async_V", 32'(V), 0);
    chk("t6_async_tk", 32'(tickets), 0);
    tick();
    reset = 1;
    tick();
    bet(7);
    chk("t6_ignored_V", 32'(V), 0);

    // end_bets with no bets in ARMED
    drive(1, pack(7, 19, 42), 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("t7_V_low", 32'(V), 0);
    chk("t7_fin_low", 32'(finish), 0);
    tick();
    chk("t7_fin_high", 32'(finish), 1);
    chk("t7_sum0", 32'(sum), 0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      ld = ($urandom_range(0, 29) == 0);
      a  = int'($urandom_range(0, 52));
      b  = ($urandom_range(0, 5) == 0) ? a : int'($urandom_range(0, 52));
      c  = int'($urandom_range(0, 52));
      nv = ($urandom_range(0, 3) != 0);
      n  = ($urandom_range(0, 1) == 1) ? dr[$urandom_range(0, 2)] : int'($urandom_range(0, 55));
      eb = ($urandom_range(0, 24) == 0);
      drive(ld, pack(a, b, c), nv, 6'(n), eb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bet_scorer.md
# bet_scorer

Lottery bet-scoring stage that sits directly upstream of the cash/prize-display stage. It latches the three drawn numbers and accepts the player's bet numbers serially, three per ticket. It compares each number against the draw and accumulates a saturating 10-bit prize `sum`. It drives `V` and `finish` with the ordering the display stage needs to sample `sum` on the rising edge of `finish`.

## Interface
- `PRIZE1`, default 3: prize for a ticket with 1 match.
- `PRIZE2`, default 27: prize for a ticket with 2 matches.
- `PRIZE3`, default 250: prize for a ticket with 3 matches.
- `SUM_MAX`, default 799: saturation ceiling for `sum`.
- `MAX_TICKETS`, default 15: when this many tickets complete, the game closes automatically.
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `load_draw` input, 1 bit: latch `draw_in` (accepted in IDLE, ARMED and HOLD).
- `draw_in` input, 18 bits: three 6-bit drawn numbers, [17:12], [11:6] and [5:0].
- `N_in` input, 6 bits: bet number.
- `N_valid` input, 1 bit: `N_in` is valid this cycle.
- `end_bets` input, 1 bit: player has finished betting.
- `sum` output, 10 bits: accumulated prize, in euro.
- `V` output, 1 bit: high while a game is collecting bets.
- `finish` output, 1 bit: one-cycle pulse marking that `sum` is final.
- `tickets` output, 4 bits: number of completed tickets in the current game.
- `err` output, 1 bit: one-cycle pulse when a number or draw is rejected.

## Operation
- A number is legal if it lies in 1..49.
- A draw is legal only if all three numbers are legal and pairwise distinct. An illegal draw pulses `err` and changes no other state.
- States and transitions:
  - IDLE: no draw loaded. `N_valid` is ignored. A legal `load_draw` moves to ARMED.
  - ARMED: the draw is loaded.
    - A legal number starts a game: `sum`←0, `tickets`←0, `V`←1, the number becomes index 0, go to BET.
    - `end_bets` goes to CLOSE with `sum`=0.
  - BET: each accepted number is compared against all three draw numbers; `mcnt` (2 bits) accumulates matches.
    - On the third number of a ticket, at the same edge: `sum`←min(`sum`+prize(`mcnt` plus the current number's match), `SUM_MAX`); `tickets`++; index←0; `mcnt`←0.
    - Prize by match count: 0 matches pays 0, 1 pays `PRIZE1`, 2 pays `PRIZE2`, 3 pays `PRIZE3`.
    - Adder width is 11 bits before saturation.
    - `end_bets`, or `tickets` reaching `MAX_TICKETS`, goes to CLOSE.
  - CLOSE (1 cycle): `V`←0; partial-ticket state is discarded.
  - FIN (1 cycle): `finish`=1.
  - HOLD: `sum` and `tickets` are held.
    - A legal number starts a new game exactly as in ARMED.
    - `load_draw` replaces the draw.
- An illegal number with `N_valid` pulses `err` the next cycle. It is not counted, does not advance the index, and leaves the state unchanged.
- Duplicate bet numbers within a ticket are accepted and scored independently.
- `N_valid` together with `end_bets` in the same BET cycle: the number is processed first; if it completes a ticket, that ticket is scored, then the game closes.
- `load_draw` in BET, CLOSE or FIN is ignored. All inputs are ignored in CLOSE and FIN.
- If `load_draw` and `N_valid` coincide in ARMED or HOLD, the new draw is taken and the number is ignored.
- Reset (asynchronous, any state): state←IDLE; `sum`=0, `V`=0, `finish`=0, `tickets`=0, `err`=0; draw registers, index and `mcnt` cleared.

## Timing
- One bet number can be accepted every cycle, with no stall.
- `sum` and `tickets` update at the edge that samples the ticket's third number.
- Close sequence, where edge e samples `end_bets` (or completes ticket `MAX_TICKETS`):
  - edge e: `V` falls (state CLOSE).
  - edge e+1: `finish` rises.
  - edge e+2: `finish` falls (state HOLD).
- `V` is therefore low for at least one full cycle before `finish` rises.
- `sum` is stable from edge e until a new game starts, i.e. for the whole `finish` pulse.
- `err` is registered: high for exactly one cycle, starting one edge after the offending input is sampled.

## Test plan
- Draw 7,19,42. Tickets 7,19,3 then 42,19,7. Then bet 7 and pulse `end_bets`. Required: `sum`=277, `tickets`=2, partial ticket discarded. `V` falls one cycle before the single-cycle `finish` pulse; `sum` holds 277 in HOLD.
- Four tickets each scoring 3 matches, then `end_bets`. Required: `sum` reads 250, 500, 750, then 799 (saturated).
- Bet `N_in`=0, then 50, then 19. Required: two one-cycle `err` pulses; only 19 is counted (index 1).
- Draw 5,5,9. Required: `err` pulse and the block stays in IDLE. Then bet 5 with `N_valid`: required no response.
- Fifteen tickets, each with exactly one match, and no `end_bets`. Required: `sum`=45, `tickets`=15, automatic CLOSE, then `finish` pulse.
- Assert `reset` low mid-ticket while `sum`=27. Required: all outputs 0 immediately. After reset, `N_valid` is ignored until a new legal draw is loaded.
- In ARMED, pulse `end_bets` with no bets. Required: `V` stays 0, `sum`=0, `finish` pulses at edge e+1.
